dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage and a debug/loader requester.
- The CPU has priority. A starvation counter forces one debug slot after MAX_WAIT blocked cycles.
- During a forced slot the block freezes the pipeline for one cycle with pipe_stall.
- Sits between EX_MEM outputs and the DM instance, in the MEM stage of the 5-stage pipeline.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- MAX_WAIT, 4, blocked debug cycles before a forced grant (legal range 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_mem_r  in  1  MEM-stage read request
- cpu_mem_w  in  1  MEM-stage write request
- cpu_addr  in  ADDR_W  MEM-stage address (ALU result)
- cpu_wdata  in  DATA_W  MEM-stage write data
- cpu_rdata  out  DATA_W  read data to MEM_WB; passthrough of dm_rdata
- pipe_stall  out  1  freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB this cycle
- dbg_valid  in  1  debug request valid
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ready  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  one-cycle pulse: dbg_rdata is valid
- dbg_rdata  out  DATA_W  registered debug read data
- dm_mem_r  out  1  to DM Mem_r
- dm_mem_w  out  1  to DM Mem_w
- dm_addr  out  ADDR_W  to DM Mem_addr
- dm_wdata  out  DATA_W  to DM Mem_w_data
- dm_rdata  in  DATA_W  from DM Mem_r_data (combinational read)

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: state=IDLE, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0.
  - While rst=1, the combinational outputs dbg_ready, pipe_stall, dm_mem_r and dm_mem_w are forced to 0.
- Internal signals:
  - cpu_act = cpu_mem_r | cpu_mem_w
  - starve = (wait_cnt == MAX_WAIT)
  - grant = dbg_valid & (state != RESP) & (~cpu_act | starve)
- Outputs, all combinational:
  - dbg_ready = grant
  - pipe_stall = grant & cpu_act
- DM mux when grant=1:
  - dm_addr=dbg_addr, dm_wdata=dbg_wdata, dm_mem_w=dbg_we, dm_mem_r=~dbg_we.
  - Any concurrent CPU access is suppressed, not merely delayed. The frozen pipeline re-presents it next cycle.
- DM mux otherwise: CPU signals pass straight through to DM.
- cpu_rdata = dm_rdata always. It is meaningful only when the CPU owns the port.
- Handshake:
  - Transfer happens when dbg_valid & dbg_ready.
  - The requester holds dbg_valid and its payload stable until accepted.
  - Only one read may be outstanding at a time.
- Read response:
  - At the grant edge, dbg_rdata <= dm_rdata.
  - dbg_rvalid = 1 for exactly the next cycle, which is state RESP.
  - Writes produce no response.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: grant & ~dbg_we -> RESP; grant & dbg_we -> IDLE; dbg_valid & ~grant -> WAIT.
  - WAIT: grant -> RESP for a read, IDLE for a write; otherwise stay.
  - RESP: dbg_ready is held 0. Next state is WAIT if dbg_valid, else IDLE.
- wait_cnt (4 bits):
  - Cleared on grant, or whenever dbg_valid=0.
  - Incremented on dbg_valid & ~grant, saturating at MAX_WAIT.
  - Clearing on grant blocks back-to-back forced slots: after a forced grant the CPU owns at least the next MAX_WAIT cycles.
- Boundary cases:
  - CPU idle: debug is granted the same cycle dbg_valid rises, with zero wait.
  - MAX_WAIT reached while the CPU is idle: ordinary grant, pipe_stall=0.
  - Reset asserted during a grant cycle: DM write is suppressed and any pending dbg_rvalid is dropped.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - default MAX_WAIT
  - the pipe_stall freeze contract used by the pipeline registers
- One natural sub-module: arb_wait_counter, the saturating clear/increment counter with a starve output.

Test Plan:
- Idle CPU, DM[0x10]=0xDEADBEEF, debug read 0x10 -> dbg_ready same cycle, pipe_stall=0; next cycle dbg_rvalid=1, dbg_rdata=0xDEADBEEF.
- cpu_mem_r=1 every cycle, debug write 0x20=0x1234 from cycle 0, MAX_WAIT=4:
  - cycles 0-3: dbg_ready=0.
  - cycle 4: dbg_ready=1, pipe_stall=1, dm_mem_w=1, dm_addr=0x20.
  - cycle 5: CPU owns the port.
- cpu_mem_w=1 to 0x8 together with debug write to 0x8, wait_cnt=0 -> CPU write occurs, dbg_ready=0, pipe_stall=0, wait_cnt=1.
- Two back-to-back debug reads, CPU idle -> first ready at cycle 0, RESP at cycle 1 with dbg_ready=0, second ready at cycle 2.
- Forced write grant, then dbg_valid held high with the CPU still busy -> no grant for the next 4 cycles; wait_cnt restarts at 0.
- rst pulsed during a granted read cycle -> dm_mem_r=0, dbg_rvalid stays 0, state=IDLE, wait_cnt=0 after release.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding, starvation defaults
// and the stall contract honoured by the pipeline registers.
package dm_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } arb_state_e;

    localparam int DEFAULT_MAX_WAIT = 4;
    localparam int WAIT_CNT_W       = 4;

    // PC, IF_ID, ID_EX, EX_MEM and MEM_WB load only when this is 1; a stalled cycle
    // holds every stage so the suppressed MEM access is re-presented next cycle.
    function automatic logic pipe_reg_load(input logic pipe_stall);
        return ~pipe_stall;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between the MEM stage, the debug/loader requester and the data memory.
// slave = arbiter view, master = environment view.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_mem_r;
    logic              cpu_mem_w;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              pipe_stall;

    logic              dbg_valid;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ready;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              dm_mem_r;
    logic              dm_mem_w;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    modport slave (
        input  cpu_mem_r, cpu_mem_w, cpu_addr, cpu_wdata,
        output cpu_rdata, pipe_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output dm_mem_r, dm_mem_w, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output cpu_mem_r, cpu_mem_w, cpu_addr, cpu_wdata,
        input  cpu_rdata, pipe_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  dm_mem_r, dm_mem_w, dm_addr, dm_wdata,
        output dm_rdata
    );

endinterface

// File: rtl/dm_port_arbiter_arb_wait_counter.sv
// Counts cycles a debug request has been blocked; starve tells the arbiter to force a slot.
module arb_wait_counter
    import dm_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic dbg_valid,
    input  logic grant,
    output logic starve
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;

    // Clearing on grant guarantees the CPU at least MAX_WAIT cycles after a forced slot.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant || !dbg_valid) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign starve = (wait_cnt_q == LIMIT);

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port data-memory arbiter: MEM stage has priority, debug/loader gets a forced
// slot (with a one-cycle pipeline freeze) after MAX_WAIT blocked cycles.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input logic               clk,
    input logic               rst,
    dm_port_arbiter_if.slave  bus
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              dbg_rvalid_q;
    logic              dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_d;

    logic              cpu_act;
    logic              starve;
    logic              grant;
    logic              read_grant;

    logic              dm_mem_r_mux;
    logic              dm_mem_w_mux;
    logic [ADDR_W-1:0] dm_addr_mux;
    logic [DATA_W-1:0] dm_wdata_mux;

    assign cpu_act    = bus.cpu_mem_r | bus.cpu_mem_w;
    assign grant      = bus.dbg_valid & (state_q != RESP) & (~cpu_act | starve);
    assign read_grant = grant & ~bus.dbg_we;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .dbg_valid (bus.dbg_valid),
        .grant     (grant),
        .starve    (starve)
    );

    // A granted debug access replaces the CPU access outright; the stall makes the CPU retry.
    always_comb begin
        dm_mem_r_mux = bus.cpu_mem_r;
        dm_mem_w_mux = bus.cpu_mem_w;
        dm_addr_mux  = bus.cpu_addr;
        dm_wdata_mux = bus.cpu_wdata;
        if (grant) begin
            dm_mem_r_mux = ~bus.dbg_we;
            dm_mem_w_mux = bus.dbg_we;
            dm_addr_mux  = bus.dbg_addr;
            dm_wdata_mux = bus.dbg_wdata;
        end
    end

    assign bus.dm_mem_r   = dm_mem_r_mux & ~rst;
    assign bus.dm_mem_w   = dm_mem_w_mux & ~rst;
    assign bus.dm_addr    = dm_addr_mux;
    assign bus.dm_wdata   = dm_wdata_mux;
    assign bus.cpu_rdata  = bus.dm_rdata;
    assign bus.dbg_ready  = grant & ~rst;
    assign bus.pipe_stall = grant & cpu_act & ~rst;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

    always_comb begin
        state_d      = state_q;
        dbg_rvalid_d = read_grant;
        dbg_rdata_d  = read_grant ? bus.dm_rdata : dbg_rdata_q;
        case (state_q)
            IDLE, WAIT: begin
                if (grant) begin
                    state_d = bus.dbg_we ? IDLE : RESP;
                end else if (bus.dbg_valid) begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = bus.dbg_valid ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus a randomized run, all checked
// against a cycle-level behavioural model of the arbitration rules and a shadow memory.
module tb_dm_port_arbiter;

    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dm_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic bit [31:0] init_val(input int unsigned a);
        return 32'hC0DE_0000 ^ (a * 32'h0001_0103);
    endfunction

    // Data memory: combinational read, write on the rising edge.
    bit [31:0] dm_mem [256];
    bit        dm_wr  [256];
    always @(posedge clk) begin
        if (bus.dm_mem_w === 1'b1) begin
            dm_mem[bus.dm_addr[7:0]] <= bus.dm_wdata;
            dm_wr[bus.dm_addr[7:0]]  <= 1'b1;
        end
    end
    assign bus.dm_rdata = dm_wr[bus.dm_addr[7:0]] ? dm_mem[bus.dm_addr[7:0]]
                                                  : init_val(32'(bus.dm_addr[7:0]));

    // Reference model state
    bit [31:0] ref_mem [256];
    int        m_wait;
    bit        m_resp;
    bit [31:0] m_rdata;

    // Last applied stimulus and the expectations derived from it
    bit        a_cr, a_cw, a_dv, a_dwe;
    bit [31:0] a_ca, a_cwd, a_da, a_dwd;
    bit        e_ready, e_stall, e_mr, e_mw, e_rvalid;
    bit [31:0] e_addr, e_wdata, e_rdata, e_cpu_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic apply(input bit cr, input bit cw, input bit [31:0] ca, input bit [31:0] cwd,
                         input bit dv, input bit dwe, input bit [31:0] da, input bit [31:0] dwd);
        bit busy;
        a_cr = cr; a_cw = cw; a_ca = ca; a_cwd = cwd;
        a_dv = dv; a_dwe = dwe; a_da = da; a_dwd = dwd;
        bus.cpu_mem_r = cr;  bus.cpu_mem_w = cw;  bus.cpu_addr = ca; bus.cpu_wdata = cwd;
        bus.dbg_valid = dv;  bus.dbg_we    = dwe; bus.dbg_addr = da; bus.dbg_wdata = dwd;
        @(negedge clk);
        busy        = cr || cw;
        e_ready     = !rst && dv && !m_resp && (!busy || m_wait >= MW);
        e_stall     = e_ready && busy;
        e_mr        = !rst && (e_ready ? !dwe : cr);
        e_mw        = !rst && (e_ready ? dwe : cw);
        e_addr      = e_ready ? da : ca;
        e_wdata     = e_ready ? dwd : cwd;
        e_rvalid    = !rst && m_resp;
        e_rdata     = rst ? 32'h0 : m_rdata;
        e_cpu_rdata = ref_mem[ca[7:0]];
    endtask

    task automatic tick();
        if (rst) begin
            m_wait  = 0;
            m_resp  = 1'b0;
            m_rdata = 32'h0;
        end else if (e_ready) begin
            $display("[%0t] dbg %s addr=0x%0h data=0x%0h stall=%0b", $time,
                     a_dwe ? "write" : "read ", a_da,
                     a_dwe ? a_dwd : ref_mem[a_da[7:0]], e_stall);
            if (a_dwe) ref_mem[a_da[7:0]] = a_dwd;
            else       m_rdata = ref_mem[a_da[7:0]];
            m_resp = !a_dwe;
            m_wait = 0;
        end else begin
            if (a_cw) ref_mem[a_ca[7:0]] = a_cwd;
            m_resp = 1'b0;
            m_wait = a_dv ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(0, 1, 32'h8, 32'h5, 1, 0, 32'h10, 0);
        n_cmp++; if (bus.dbg_ready !== 1'b0)  begin n_fail++; $display("FAIL reset ready: got %0b want 0", bus.dbg_ready); end
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %0b want 0", bus.pipe_stall); end
        n_cmp++; if (bus.dm_mem_w !== 1'b0)   begin n_fail++; $display("FAIL reset mem_w: got %0b want 0", bus.dm_mem_w); end
        n_cmp++; if (bus.dm_mem_r !== 1'b0)   begin n_fail++; $display("FAIL reset mem_r: got %0b want 0", bus.dm_mem_r); end
        n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset rvalid: got %0b want 0", bus.dbg_rvalid); end
        n_cmp++; if (bus.dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset rdata: got %h want 0", bus.dbg_rdata); end
        tick();
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_idle_read();
        apply(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        n_cmp++; if (bus.dm_mem_w !== 1'b1 || bus.dm_addr !== 32'h10)
            begin n_fail++; $display("FAIL idle_read cpu_wr: got w=%0b a=%h want w=1 a=10", bus.dm_mem_w, bus.dm_addr); end
        tick();
        apply(0, 0, 0, 0, 1, 0, 32'h10, 0);
        n_cmp++; if (bus.dbg_ready !== 1'b1)  begin n_fail++; $display("FAIL idle_read ready: got %0b want 1", bus.dbg_ready); end
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL idle_read stall: got %0b want 0", bus.pipe_stall); end
        n_cmp++; if (bus.dm_mem_r !== 1'b1)   begin n_fail++; $display("FAIL idle_read mem_r: got %0b want 1", bus.dm_mem_r); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.dbg_rvalid !== 1'b1) begin n_fail++; $display("FAIL idle_read rvalid: got %0b want 1", bus.dbg_rvalid); end
        n_cmp++; if (bus.dbg_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_read rdata: got %h want deadbeef", bus.dbg_rdata); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_read rvalid_pulse: got %0b want 0", bus.dbg_rvalid); end
        tick();
    endtask

    task automatic test_starve_write();
        for (int c = 0; c < 6; c++) begin
            apply(1, 0, 32'h40, 0, c <= 4, 1, 32'h20, 32'h1234);
            n_cmp++; if (bus.dbg_ready !== (c == 4))
                begin n_fail++; $display("FAIL starve ready c%0d: got %0b want %0b", c, bus.dbg_ready, c == 4); end
            if (c == 4) begin
                n_cmp++; if (bus.pipe_stall !== 1'b1 || bus.dm_mem_w !== 1'b1 || bus.dm_mem_r !== 1'b0 || bus.dm_addr !== 32'h20)
                    begin n_fail++; $display("FAIL starve forced: got stall=%0b w=%0b r=%0b a=%h want 1 1 0 20",
                                             bus.pipe_stall, bus.dm_mem_w, bus.dm_mem_r, bus.dm_addr); end
            end
            if (c == 5) begin
                n_cmp++; if (bus.pipe_stall !== 1'b0 || bus.dm_mem_r !== 1'b1 || bus.dm_addr !== 32'h40)
                    begin n_fail++; $display("FAIL starve cpu_owns: got stall=%0b r=%0b a=%h want 0 1 40",
                                             bus.pipe_stall, bus.dm_mem_r, bus.dm_addr); end
            end
            tick();
        end
        apply(0, 0, 0, 0, 1, 0, 32'h20, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'h1234)
            begin n_fail++; $display("FAIL starve readback: got v=%0b d=%h want 1 1234", bus.dbg_rvalid, bus.dbg_rdata); end
        tick();
    endtask

    task automatic test_cpu_collision();
        apply(0, 1, 32'h8, 32'hAAAA5555, 1, 1, 32'h8, 32'h7777);
        n_cmp++; if (bus.dbg_ready !== 1'b0 || bus.pipe_stall !== 1'b0)
            begin n_fail++; $display("FAIL collide arb: got ready=%0b stall=%0b want 0 0", bus.dbg_ready, bus.pipe_stall); end
        n_cmp++; if (bus.dm_mem_w !== 1'b1 || bus.dm_addr !== 32'h8 || bus.dm_wdata !== 32'hAAAA5555)
            begin n_fail++; $display("FAIL collide cpu_wr: got w=%0b a=%h d=%h want 1 8 aaaa5555",
                                     bus.dm_mem_w, bus.dm_addr, bus.dm_wdata); end
        tick();
        // wait count is now 1, so the forced slot arrives after three more blocked cycles
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 32'h8, 32'hAAAA5555, 1, 1, 32'h8, 32'h7777);
            n_cmp++; if (bus.dbg_ready !== (k == 3))
                begin n_fail++; $display("FAIL collide wait k%0d: got %0b want %0b", k, bus.dbg_ready, k == 3); end
            tick();
        end
        apply(0, 0, 0, 0, 1, 0, 32'h8, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.dbg_rdata !== 32'h7777)
            begin n_fail++; $display("FAIL collide readback: got %h want 7777", bus.dbg_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        apply(0, 0, 0, 0, 1, 0, 32'h3, 0);
        n_cmp++; if (bus.dbg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready0: got %0b want 1", bus.dbg_ready); end
        tick();
        apply(0, 0, 0, 0, 1, 0, 32'h5, 0);
        n_cmp++; if (bus.dbg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b ready1: got %0b want 0", bus.dbg_ready); end
        n_cmp++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== ref_mem[3])
            begin n_fail++; $display("FAIL b2b resp1: got v=%0b d=%h want 1 %h", bus.dbg_rvalid, bus.dbg_rdata, ref_mem[3]); end
        tick();
        apply(0, 0, 0, 0, 1, 0, 32'h5, 0);
        n_cmp++; if (bus.dbg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready2: got %0b want 1", bus.dbg_ready); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== ref_mem[5])
            begin n_fail++; $display("FAIL b2b resp2: got v=%0b d=%h want 1 %h", bus.dbg_rvalid, bus.dbg_rdata, ref_mem[5]); end
        tick();
    endtask

    task automatic test_no_double_force();
        for (int c = 0; c < 10; c++) begin
            apply(1, 0, 32'h44, 0, 1, 1, (c < 5) ? 32'h30 : 32'h31, 32'(c));
            n_cmp++; if (bus.dbg_ready !== (c == 4 || c == 9))
                begin n_fail++; $display("FAIL no_double c%0d: got %0b want %0b", c, bus.dbg_ready, c == 4 || c == 9); end
            tick();
        end
        idle_cycle();
    endtask

    task automatic test_reset_during_grant();
        for (int c = 0; c < 2; c++) begin
            apply(1, 0, 32'h44, 0, 1, 1, 32'h50, 32'h99);
            tick();
        end
        rst = 1'b1;
        apply(0, 0, 0, 0, 1, 0, 32'h10, 0);
        n_cmp++; if (bus.dm_mem_r !== 1'b0 || bus.dbg_ready !== 1'b0)
            begin n_fail++; $display("FAIL rst_grant comb: got r=%0b ready=%0b want 0 0", bus.dm_mem_r, bus.dbg_ready); end
        tick();
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_grant rvalid: got %0b want 0", bus.dbg_rvalid); end
        tick();
        for (int k = 0; k < 5; k++) begin
            apply(1, 0, 32'h44, 0, 1, 1, 32'h51, 32'h55);
            n_cmp++; if (bus.dbg_ready !== (k == 4))
                begin n_fail++; $display("FAIL rst_grant wait k%0d: got %0b want %0b", k, bus.dbg_ready, k == 4); end
            tick();
        end
        idle_cycle();
    endtask

    task automatic test_random();
        bit        p_v;
        bit        p_we;
        bit [31:0] p_a, p_d;
        int        r;
        p_v = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!p_v && $urandom_range(0, 2) != 0) begin
                p_v  = 1'b1;
                p_we = 1'($urandom_range(0, 1));
                p_a  = 32'($urandom_range(0, 15));
                p_d  = $urandom;
            end
            r = int'($urandom_range(0, 3));
            apply(r == 1, r == 2, 32'($urandom_range(0, 15)), $urandom, p_v, p_we, p_a, p_d);
            n_cmp++; if (bus.dbg_ready !== e_ready)   begin n_fail++; $display("FAIL rand ready c%0d: got %0b want %0b", c, bus.dbg_ready, e_ready); end
            n_cmp++; if (bus.pipe_stall !== e_stall)  begin n_fail++; $display("FAIL rand stall c%0d: got %0b want %0b", c, bus.pipe_stall, e_stall); end
            n_cmp++; if (bus.dm_mem_r !== e_mr || bus.dm_mem_w !== e_mw)
                begin n_fail++; $display("FAIL rand dm_ctl c%0d: got r=%0b w=%0b want r=%0b w=%0b", c, bus.dm_mem_r, bus.dm_mem_w, e_mr, e_mw); end
            if (e_mr || e_mw) begin
                n_cmp++; if (bus.dm_addr !== e_addr) begin n_fail++; $display("FAIL rand addr c%0d: got %h want %h", c, bus.dm_addr, e_addr); end
            end
            if (e_mw) begin
                n_cmp++; if (bus.dm_wdata !== e_wdata) begin n_fail++; $display("FAIL rand wdata c%0d: got %h want %h", c, bus.dm_wdata, e_wdata); end
            end
            n_cmp++; if (bus.dbg_rvalid !== e_rvalid) begin n_fail++; $display("FAIL rand rvalid c%0d: got %0b want %0b", c, bus.dbg_rvalid, e_rvalid); end
            if (e_rvalid) begin
                n_cmp++; if (bus.dbg_rdata !== e_rdata) begin n_fail++; $display("FAIL rand rdata c%0d: got %h want %h", c, bus.dbg_rdata, e_rdata); end
            end
            if (a_cr && !e_ready) begin
                n_cmp++; if (bus.cpu_rdata !== e_cpu_rdata) begin n_fail++; $display("FAIL rand cpu_rdata c%0d: got %h want %h", c, bus.cpu_rdata, e_cpu_rdata); end
            end
            if (e_ready) p_v = 1'b0;
            tick();
        end
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_mem_r = 1'b0; bus.cpu_mem_w = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_valid = 1'b0; bus.dbg_we    = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_wait = 0; m_resp = 1'b0; m_rdata = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_idle_read();
        test_starve_write();
        test_cpu_collision();
        test_back_to_back();
        test_no_double_force();
        test_reset_during_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
